regfile_sb: RTL



---
 rtl/regfile_sb_if.sv | 28 ++
 rtl/regfile_sb.sv | 104 ++++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Register-file port bundle: two read ports, one write port, issue port,
// scoreboard status and the clear/ready handshake.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            clr_req;
  logic            ready;
  logic [AW-1:0]   ra1, ra2;
  logic [XLEN-1:0] rd1, rd2;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            busy1, busy2;

  modport master (
    output clr_req, ra1, ra2, we, wa, wd, iss_valid, iss_rd,
    input  ready, rd1, rd2, busy1, busy2
  );
  modport slave (
    input  clr_req, ra1, ra2, we, wa, wd, iss_valid, iss_rd,
    output ready, rd1, rd2, busy1, busy2
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard and a self-clearing sweep.
// Optional macro RF_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [NREGS-1:0] sb_q, sb_d;
  logic [XLEN-1:0] rf_q [NREGS];

  logic run, wr_en, iss_en;
  logic [1:0][AW-1:0]   ra;
  logic [1:0][XLEN-1:0] rd;
  logic [1:0]           busy;

  assign run    = (state_q == RUN);
  // A clear request in RUN discards any write or issue sampled with it.
  assign wr_en  = run && bus.we && !bus.clr_req && !(ZERO_REG && bus.wa == '0);
  assign iss_en = run && bus.iss_valid && !bus.clr_req && !(ZERO_REG && bus.iss_rd == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sb_q    <= sb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = RUN;
      end
      RUN: begin
        if (bus.clr_req) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Issue after write-clear so a new producer supersedes the retiring one.
  always_comb begin
    sb_d = sb_q;
    if (run && bus.clr_req) begin
      sb_d = '0;
    end else begin
      if (wr_en)  sb_d[bus.wa]     = 1'b0;
      if (iss_en) sb_d[bus.iss_rd] = 1'b1;
    end
  end

  // Storage has no reset; the INIT sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!run)       rf_q[ptr_q]  <= '0;
    else if (wr_en) rf_q[bus.wa] <= bus.wd;
  end

  assign ra[0] = bus.ra1;
  assign ra[1] = bus.ra2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p]   = '0;
      busy[p] = 1'b0;
      if (run) begin
        if (!(ZERO_REG && ra[p] == '0)) rd[p] = rf_q[ra[p]];
        busy[p] = sb_q[ra[p]];
`ifdef RF_BYPASS_EN
        if (bus.we && bus.wa == ra[p]) begin
          busy[p] = 1'b0;
          if (!(ZERO_REG && bus.wa == '0)) rd[p] = bus.wd;
        end
`endif
      end
    end
  end

  assign bus.ready = run;
  assign bus.rd1   = rd[0];
  assign bus.rd2   = rd[1];
  assign bus.busy1 = busy[0];
  assign bus.busy2 = busy[1];
endmodule
